// File: rtl/nco_note_sequencer.sv
// Note sequencer for the NCO: free-running sample strobe plus a (fcw, duration) command
// stream with a one-entry pending slot so consecutive notes play without a silent gap.
module nco_note_sequencer #(
    parameter int SAMPLE_DIV = 1024,
    parameter int FCW_W      = 24,
    parameter int DUR_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [FCW_W-1:0] cmd_fcw,
    input  logic [DUR_W-1:0] cmd_dur,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             flush,
    output logic [FCW_W-1:0] nco_fcw,
    output logic             nco_next_sample,
    output logic             busy,
    output logic             note_done
);

    localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SAMPLE_DIV - 1);

    typedef enum logic {
        IDLE,
        PLAY
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] tick_cnt;
    logic             pend_valid;
    logic [FCW_W-1:0] pend_fcw;
    logic [DUR_W-1:0] pend_dur;
    logic [FCW_W-1:0] cur_fcw;
    logic [DUR_W-1:0] remaining;
    logic             load;
    logic             done_nxt;
    logic             accept;
    logic             tick;

    // A zero-length note still occupies one sample.
    function automatic logic [DUR_W-1:0] dur_clamp(input logic [DUR_W-1:0] d);
        return (d == '0) ? DUR_W'(1) : d;
    endfunction

    assign tick      = nco_next_sample;
    assign cmd_ready = !pend_valid;
    assign accept    = cmd_valid && !pend_valid && !flush;
    assign busy      = (state == PLAY);
    assign nco_fcw   = busy ? cur_fcw : '0;

    // Sample strobe: registered so it is high for the cycle after tick_cnt wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt        <= '0;
            nco_next_sample <= 1'b0;
        end else begin
            tick_cnt        <= (tick_cnt == CNT_MAX) ? '0 : tick_cnt + 1'b1;
            nco_next_sample <= (tick_cnt == CNT_MAX);
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        done_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (pend_valid) begin
                    load      = 1'b1;
                    state_nxt = PLAY;
                end
            end
            PLAY: begin
                if (tick && remaining == DUR_W'(1)) begin
                    done_nxt = 1'b1;
                    if (pend_valid) load = 1'b1;
                    else            state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt = IDLE;
            load      = 1'b0;
            done_nxt  = 1'b0;
        end
    end

    // Control state: FSM, pending-slot occupancy, sample countdown, completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pend_valid <= 1'b0;
            remaining  <= '0;
            note_done  <= 1'b0;
        end else begin
            state     <= state_nxt;
            note_done <= done_nxt;
            if (flush || load) pend_valid <= 1'b0;
            else if (accept)   pend_valid <= 1'b1;
            if (load)                     remaining <= dur_clamp(pend_dur);
            else if (state == PLAY && tick) remaining <= remaining - 1'b1;
        end
    end

    // Note payload registers; nco_fcw is gated by state, so these need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            pend_fcw <= cmd_fcw;
            pend_dur <= cmd_dur;
        end
        if (load) cur_fcw <= pend_fcw;
    end

endmodule

// File: tb/tb_nco_note_sequencer.sv
// Directed and randomized checks of nco_note_sequencer with SAMPLE_DIV=4.
module tb_nco_note_sequencer;

    localparam int SAMPLE_DIV = 4;
    localparam int FCW_W      = 24;
    localparam int DUR_W      = 16;
    localparam int NNOTES     = 100;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [FCW_W-1:0] cmd_fcw = '0;
    logic [DUR_W-1:0] cmd_dur = '0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic             flush = 1'b0;
    logic [FCW_W-1:0] nco_fcw;
    logic             nco_next_sample;
    logic             busy;
    logic             note_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    bit mon_en = 0;
    bit xfer_last = 0;

    logic [FCW_W-1:0] nf [NNOTES];
    logic [DUR_W-1:0] nd [NNOTES];
    int rcv = 0;
    int snd = 0;
    int note_cnt = 0;
    bit note_bad = 0;

    nco_note_sequencer #(
        .SAMPLE_DIV(SAMPLE_DIV),
        .FCW_W(FCW_W),
        .DUR_W(DUR_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd_fcw(cmd_fcw),
        .cmd_dur(cmd_dur),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .flush(flush),
        .nco_fcw(nco_fcw),
        .nco_next_sample(nco_next_sample),
        .busy(busy),
        .note_done(note_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    // Advance one clock; everything is observed and driven 1 time unit after the edge.
    task automatic step();
        xfer_last = rst_n && cmd_valid && cmd_ready && !flush;
        @(posedge clk);
        #1;
        cyc++;
        if (rst_n) begin
            check("strobe", {31'd0, nco_next_sample}, {31'd0, (cyc % SAMPLE_DIV == 0)});
            if (note_done) done_cnt++;
        end
        if (mon_en && rst_n) begin
            if (note_done && rcv < NNOTES) begin
                check("note_len", note_cnt, (nd[rcv] == '0) ? 1 : int'(nd[rcv]));
                check("note_fcw_ok", {31'd0, note_bad}, 32'd0);
                rcv++;
                note_cnt = 0;
                note_bad = 0;
            end
            if (nco_next_sample && busy && rcv < NNOTES) begin
                note_cnt++;
                if (nco_fcw !== nf[rcv]) note_bad = 1;
            end
        end
    endtask

    task automatic step_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic send(input logic [FCW_W-1:0] f, input logic [DUR_W-1:0] d);
        cmd_fcw   = f;
        cmd_dur   = d;
        cmd_valid = 1'b1;
    endtask

    initial begin
        int d0;
        int guard;

        // reset state
        step();
        step();
        check("rst_fcw", nco_fcw, 0);
        check("rst_busy", busy, 0);
        check("rst_strobe", nco_next_sample, 0);
        check("rst_done", note_done, 0);
        check("rst_ready", cmd_ready, 1);
        rst_n = 1'b1;
        cyc = 0;

        // 1) idle strobes
        step_to(8);
        check("idle_fcw", nco_fcw, 0);
        check("idle_ready", cmd_ready, 1);
        check("idle_busy", busy, 0);

        // 2) single note {0x10000,3}
        d0 = done_cnt;
        send(24'h010000, 16'd3);
        step_to(9);
        cmd_valid = 1'b0;
        check("n1_ready_full", cmd_ready, 0);
        check("n1_fcw_pre", nco_fcw, 0);
        step_to(10);
        check("n1_fcw_load", nco_fcw, 32'h10000);
        check("n1_busy", busy, 1);
        check("n1_ready", cmd_ready, 1);
        step_to(20);
        check("n1_fcw_last", nco_fcw, 32'h10000);
        step_to(21);
        check("n1_done", note_done, 1);
        check("n1_fcw_end", nco_fcw, 0);
        check("n1_busy_end", busy, 0);
        step_to(22);
        check("n1_done_clr", note_done, 0);
        check("n1_done_cnt", done_cnt - d0, 1);

        // 3) back-to-back notes with valid held
        send(24'd60508, 16'd2);
        step_to(23);
        send(24'h020000, 16'd2);
        check("b2b_ready0", cmd_ready, 0);
        step_to(24);
        check("b2b_fcw_a", nco_fcw, 60508);
        check("b2b_ready1", cmd_ready, 1);
        step_to(25);
        cmd_valid = 1'b0;
        check("b2b_ready_full", cmd_ready, 0);
        step_to(28);
        check("b2b_fcw_a_last", nco_fcw, 60508);
        check("b2b_hold_ready", cmd_ready, 0);
        step_to(29);
        check("b2b_fcw_b", nco_fcw, 32'h20000);
        check("b2b_done_a", note_done, 1);
        check("b2b_busy", busy, 1);
        check("b2b_ready_drain", cmd_ready, 1);
        step_to(36);
        check("b2b_fcw_b_last", nco_fcw, 32'h20000);
        step_to(37);
        check("b2b_fcw_end", nco_fcw, 0);
        check("b2b_done_b", note_done, 1);

        // 4) zero duration, then a rest
        send(24'h0ABCDE, 16'd0);
        step_to(38);
        cmd_valid = 1'b0;
        step_to(40);
        check("d0_fcw", nco_fcw, 32'hABCDE);
        step_to(41);
        check("d0_fcw_end", nco_fcw, 0);
        check("d0_done", note_done, 1);
        check("d0_busy", busy, 0);
        send(24'd0, 16'd2);
        step_to(42);
        cmd_valid = 1'b0;
        d0 = done_cnt;
        step_to(43);
        check("rest_busy", busy, 1);
        check("rest_fcw", nco_fcw, 0);
        step_to(48);
        check("rest_busy_last", busy, 1);
        step_to(49);
        check("rest_busy_end", busy, 0);
        check("rest_done", note_done, 1);
        step_to(50);
        check("rest_done_cnt", done_cnt - d0, 1);

        // 5) flush with a note playing and another pending
        send(24'h030000, 16'd5);
        step_to(51);
        cmd_valid = 1'b0;
        step_to(52);
        send(24'h040000, 16'd3);
        step_to(53);
        cmd_valid = 1'b0;
        check("fl_pend_full", cmd_ready, 0);
        check("fl_fcw_play", nco_fcw, 32'h30000);
        step_to(54);
        d0 = done_cnt;
        flush = 1'b1;
        step_to(55);
        check("fl_busy", busy, 0);
        check("fl_fcw", nco_fcw, 0);
        check("fl_ready", cmd_ready, 1);
        check("fl_nodone", note_done, 0);
        send(24'h060000, 16'd1);
        step_to(56);
        flush = 1'b0;
        cmd_valid = 1'b0;
        check("fl_discard_ready", cmd_ready, 1);
        step_to(57);
        check("fl_discard_busy", busy, 0);
        check("fl_done_cnt", done_cnt - d0, 0);

        // 6) asynchronous reset mid-note, no replay afterwards
        send(24'h050000, 16'd4);
        step_to(58);
        cmd_valid = 1'b0;
        step_to(59);
        check("ar_fcw_play", nco_fcw, 32'h50000);
        step_to(61);
        #3 rst_n = 1'b0;
        #1;
        check("ar_fcw", nco_fcw, 0);
        check("ar_busy", busy, 0);
        check("ar_strobe", nco_next_sample, 0);
        check("ar_ready", cmd_ready, 1);
        check("ar_done", note_done, 0);
        step();
        step();
        rst_n = 1'b1;
        cyc = 0;
        step_to(4);
        check("ar_no_replay", busy, 0);

        // randomized note stream against a per-note strobe-count model
        for (int i = 0; i < NNOTES; i++) begin
            nf[i] = ($urandom_range(0, 9) < 3) ? '0 : FCW_W'($urandom);
            nd[i] = DUR_W'($urandom_range(0, 4));
        end
        mon_en = 1;
        guard = 0;
        while (rcv < NNOTES && guard < 20000) begin
            if (snd < NNOTES && $urandom_range(0, 3) != 0) send(nf[snd], nd[snd]);
            else cmd_valid = 1'b0;
            step();
            if (xfer_last) snd++;
            guard++;
        end
        cmd_valid = 1'b0;
        check("stream_notes", rcv, NNOTES);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
